// File: rtl/pxl_readout_fifo_if.sv
// rtl/pxl_readout_fifo_if.sv - pixel readout FIFO bus: capture, pop and status signals
//
// Groups every pxl_readout_fifo signal except clk/rst.
//   master : pixel FSM / Wishbone side. Drives capture inputs, rd_en, clr_i and
//            irq_thresh, and observes rd_data and the status outputs.
//   slave  : the FIFO itself.
interface pxl_readout_fifo_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          pxl_done_i;
  logic          kernel_done_i;
  logic [3:0]    pxl_q_i;
  logic [DW-1:0] data_i;
  logic          rd_en;
  logic          clr_i;
  logic [LW-1:0] irq_thresh;

  logic [DW+4:0] rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic          irq_o;

  modport master (
    output pxl_done_i, kernel_done_i, pxl_q_i, data_i, rd_en, clr_i, irq_thresh,
    input  rd_data, rd_valid, level, empty, full, ovf, drop_cnt, irq_o
  );

  modport slave (
    input  pxl_done_i, kernel_done_i, pxl_q_i, data_i, rd_en, clr_i, irq_thresh,
    output rd_data, rd_valid, level, empty, full, ovf, drop_cnt, irq_o
  );
endinterface

// File: rtl/pxl_readout_fifo.sv
// rtl/pxl_readout_fifo.sv - edge-triggered pixel result capture FIFO with sticky overflow and level irq
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pxl_readout_fifo_if.slave
//          pxl_done_i/kernel_done_i/pxl_q_i/data_i : capture side (pixel FSM)
//          rd_en, rd_data, rd_valid                : pop side, one-cycle read latency
//          clr_i                                   : flush and clear sticky status
//          irq_thresh, irq_o                       : level interrupt (threshold 0 disables)
//          level, empty, full, ovf, drop_cnt       : status
module pxl_readout_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  pxl_readout_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DW + 5;

  // Edge-detect history
  logic          pxl_prev;
  logic          kd_prev;

  // Storage and pointers
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;

  // Output registers
  logic [EW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          ovf_q;
  logic [7:0]    drop_cnt_q;
  logic          irq_q;

  // Combinational decode
  logic          capture;
  logic          kernel_rise;
  logic          empty_c;
  logic          full_c;
  logic          rd_accept;
  logic          wr_accept;
  logic          drop;
  logic [LW-1:0] level_next;
  logic          irq_next;
  logic [EW-1:0] entry;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign capture     = bus.pxl_done_i & ~pxl_prev;
  assign kernel_rise = bus.kernel_done_i & ~kd_prev;

  assign empty_c = (level_q == '0);
  assign full_c  = (level_q == LW'(DEPTH));

  always_comb begin
    rd_accept  = 1'b0;
    wr_accept  = 1'b0;
    drop       = 1'b0;
    level_next = level_q;
    irq_next   = 1'b0;
    // A kernel-done edge coinciding with the capture tags it as well; since an
    // edge implies the level is high this reduces to the sampled level.
    entry      = {bus.kernel_done_i | kernel_rise, bus.pxl_q_i, bus.data_i};

    rd_accept = bus.rd_en & ~empty_c;
    // When full, a same-cycle pop frees the slot being written, so nothing is lost.
    wr_accept = capture & (~full_c | rd_accept);
    drop      = capture & full_c & ~rd_accept;

    level_next = level_q + LW'(wr_accept) - LW'(rd_accept);
    // Registered from level_next so irq_o changes in the same cycle as level.
    irq_next   = (bus.irq_thresh != '0) && (level_next >= bus.irq_thresh);
  end

  // Edge-detect flops: only rst clears them; clr_i must not cause a spurious
  // edge on a pxl_done_i level that is already high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_prev <= 1'b0;
      kd_prev  <= 1'b0;
    end else begin
      pxl_prev <= bus.pxl_done_i;
      kd_prev  <= bus.kernel_done_i;
    end
  end

  // Storage array has no reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (!rst && !bus.clr_i && wr_accept) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else if (bus.clr_i) begin
      // Flush; rd_data keeps the last popped word for software to inspect.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      level_q    <= level_next;
      irq_q      <= irq_next;
      rd_valid_q <= rd_accept;

      if (wr_accept) begin
        wr_ptr <= next_ptr(wr_ptr);
      end

      if (rd_accept) begin
        // Reads the pre-edge contents, so a same-cycle write at the same slot
        // (full FIFO) does not disturb the word being popped.
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= next_ptr(rd_ptr);
      end

      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.level    = level_q;
  assign bus.empty    = empty_c;
  assign bus.full     = full_c;
  assign bus.ovf      = ovf_q;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.irq_o    = irq_q;

endmodule

// File: tb/tb_pxl_readout_fifo.sv
// tb/tb_pxl_readout_fifo.sv - directed self-checking bench for pxl_readout_fifo
module tb_pxl_readout_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  pxl_readout_fifo_if #(.DEPTH(8), .DW(16)) bus_if ();

  pxl_readout_fifo #(.DEPTH(8), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic kd, input logic [3:0] q, input logic [15:0] d);
    bus_if.pxl_done_i    = 1'b1;
    bus_if.kernel_done_i = kd;
    bus_if.pxl_q_i       = q;
    bus_if.data_i        = d;
    step();
    bus_if.pxl_done_i    = 1'b0;
    bus_if.kernel_done_i = 1'b0;
    step();
  endtask

  task automatic pop();
    bus_if.rd_en = 1'b1;
    step();
    bus_if.rd_en = 1'b0;
  endtask

  task automatic clear();
    bus_if.clr_i = 1'b1;
    step();
    bus_if.clr_i = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.pxl_done_i = 0; bus_if.kernel_done_i = 0; bus_if.pxl_q_i = 0;
    bus_if.data_i = 0; bus_if.rd_en = 0; bus_if.clr_i = 0; bus_if.irq_thresh = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk_cnt++; if (bus_if.level !== 4'd0) $display("FAIL reset_level actual=%0d expected=0", bus_if.level); else pass_cnt++;
    chk_cnt++; if (bus_if.empty !== 1'b1 || bus_if.full !== 1'b0) $display("FAIL reset_empty_full actual=%b%b expected=10", bus_if.empty, bus_if.full); else pass_cnt++;
    chk_cnt++; if (bus_if.ovf !== 1'b0 || bus_if.drop_cnt !== 8'd0) $display("FAIL reset_ovf actual=%b/%0d expected=0/0", bus_if.ovf, bus_if.drop_cnt); else pass_cnt++;
    chk_cnt++; if (bus_if.rd_data !== 21'h0 || bus_if.rd_valid !== 1'b0 || bus_if.irq_o !== 1'b0) $display("FAIL reset_rd actual=%h/%b/%b expected=0/0/0", bus_if.rd_data, bus_if.rd_valid, bus_if.irq_o); else pass_cnt++;
  endtask

  task automatic test_single_capture();
    bus_if.pxl_done_i = 1'b1; bus_if.pxl_q_i = 4'd3; bus_if.data_i = 16'h1A2B; bus_if.kernel_done_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    bus_if.pxl_done_i = 1'b0;
    step();
    chk_cnt++; if (bus_if.level !== 4'd1) $display("FAIL single_level actual=%0d expected=1", bus_if.level); else pass_cnt++;
    pop();
    chk_cnt++; if (bus_if.rd_data !== 21'h031A2B) $display("FAIL single_data actual=%h expected=031a2b", bus_if.rd_data); else pass_cnt++;
    chk_cnt++; if (bus_if.rd_valid !== 1'b1 || bus_if.level !== 4'd0) $display("FAIL single_valid actual=%b/%0d expected=1/0", bus_if.rd_valid, bus_if.level); else pass_cnt++;
    step();
    chk_cnt++; if (bus_if.rd_valid !== 1'b0) $display("FAIL single_valid_pulse actual=%b expected=0", bus_if.rd_valid); else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 9; i++) pulse(1'b0, 4'd0, 16'(i));
    chk_cnt++; if (bus_if.full !== 1'b1 || bus_if.level !== 4'd8) $display("FAIL ovf_full actual=%b/%0d expected=1/8", bus_if.full, bus_if.level); else pass_cnt++;
    chk_cnt++; if (bus_if.ovf !== 1'b1 || bus_if.drop_cnt !== 8'd1) $display("FAIL ovf_flag actual=%b/%0d expected=1/1", bus_if.ovf, bus_if.drop_cnt); else pass_cnt++;
    bus_if.rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_cnt++; if (bus_if.rd_data !== 21'(i) || bus_if.rd_valid !== 1'b1) $display("FAIL ovf_pop%0d actual=%h/%b expected=%h/1", i, bus_if.rd_data, bus_if.rd_valid, 21'(i)); else pass_cnt++;
    end
    bus_if.rd_en = 1'b0;
    chk_cnt++; if (bus_if.empty !== 1'b1) $display("FAIL ovf_empty actual=%b expected=1", bus_if.empty); else pass_cnt++;
  endtask

  task automatic test_simul_full();
    logic [15:0] exp_d [9];
    clear();
    chk_cnt++; if (bus_if.ovf !== 1'b0 || bus_if.drop_cnt !== 8'd0) $display("FAIL clr_status actual=%b/%0d expected=0/0", bus_if.ovf, bus_if.drop_cnt); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      pulse(1'b0, 4'd0, 16'h10 + 16'(i));
      exp_d[i] = 16'h10 + 16'(i);
    end
    exp_d[8] = 16'hBEEF;
    bus_if.pxl_done_i = 1'b1; bus_if.data_i = 16'hBEEF; bus_if.rd_en = 1'b1;
    step();
    bus_if.pxl_done_i = 1'b0;
    chk_cnt++; if (bus_if.level !== 4'd8 || bus_if.ovf !== 1'b0) $display("FAIL simul_level actual=%0d/%b expected=8/0", bus_if.level, bus_if.ovf); else pass_cnt++;
    chk_cnt++; if (bus_if.rd_data !== {5'd0, exp_d[0]}) $display("FAIL simul_pop0 actual=%h expected=%h", bus_if.rd_data, exp_d[0]); else pass_cnt++;
    for (int i = 1; i < 9; i++) begin
      step();
      chk_cnt++; if (bus_if.rd_data !== {5'd0, exp_d[i]} || bus_if.rd_valid !== 1'b1) $display("FAIL simul_pop%0d actual=%h expected=%h", i, bus_if.rd_data, exp_d[i]); else pass_cnt++;
    end
    bus_if.rd_en = 1'b0;
    chk_cnt++; if (bus_if.empty !== 1'b1 || bus_if.ovf !== 1'b0) $display("FAIL simul_end actual=%b/%b expected=1/0", bus_if.empty, bus_if.ovf); else pass_cnt++;
  endtask

  task automatic test_empty_simul();
    bus_if.pxl_done_i = 1'b1; bus_if.data_i = 16'h0042; bus_if.pxl_q_i = 4'd0; bus_if.rd_en = 1'b1;
    step();
    bus_if.pxl_done_i = 1'b0; bus_if.rd_en = 1'b0;
    chk_cnt++; if (bus_if.level !== 4'd1 || bus_if.rd_valid !== 1'b0) $display("FAIL empty_simul actual=%0d/%b expected=1/0", bus_if.level, bus_if.rd_valid); else pass_cnt++;
    step();
    pop();
    chk_cnt++; if (bus_if.rd_data !== 21'h000042) $display("FAIL empty_simul_data actual=%h expected=000042", bus_if.rd_data); else pass_cnt++;
  endtask

  task automatic test_kernel_tag();
    pulse(1'b1, 4'd15, 16'hFFFF);
    pop();
    chk_cnt++; if (bus_if.rd_data !== 21'h1FFFFF) $display("FAIL kernel_tag actual=%h expected=1fffff", bus_if.rd_data); else pass_cnt++;
  endtask

  task automatic test_irq();
    bus_if.irq_thresh = 4'd3;
    pulse(1'b0, 4'd1, 16'h0001);
    pulse(1'b0, 4'd2, 16'h0002);
    chk_cnt++; if (bus_if.irq_o !== 1'b0) $display("FAIL irq_below actual=%b expected=0", bus_if.irq_o); else pass_cnt++;
    bus_if.pxl_done_i = 1'b1; bus_if.data_i = 16'h0003;
    step();
    bus_if.pxl_done_i = 1'b0;
    chk_cnt++; if (bus_if.irq_o !== 1'b1 || bus_if.level !== 4'd3) $display("FAIL irq_at_thresh actual=%b/%0d expected=1/3", bus_if.irq_o, bus_if.level); else pass_cnt++;
    step();
    pop();
    chk_cnt++; if (bus_if.irq_o !== 1'b0 || bus_if.level !== 4'd2) $display("FAIL irq_after_pop actual=%b/%0d expected=0/2", bus_if.irq_o, bus_if.level); else pass_cnt++;
    clear();
    bus_if.irq_thresh = 4'd0;
    for (int i = 0; i < 8; i++) pulse(1'b0, 4'd0, 16'(i));
    chk_cnt++; if (bus_if.irq_o !== 1'b0 || bus_if.level !== 4'd8) $display("FAIL irq_disabled actual=%b/%0d expected=0/8", bus_if.irq_o, bus_if.level); else pass_cnt++;
    clear();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 9; i++) pulse(1'b0, 4'd0, 16'h20 + 16'(i));
    pop(); pop(); pop();
    step();
    chk_cnt++; if (bus_if.level !== 4'd5 || bus_if.ovf !== 1'b1) $display("FAIL clr_pre actual=%0d/%b expected=5/1", bus_if.level, bus_if.ovf); else pass_cnt++;
    clear();
    chk_cnt++; if (bus_if.level !== 4'd0 || bus_if.ovf !== 1'b0 || bus_if.drop_cnt !== 8'd0) $display("FAIL clr_post actual=%0d/%b/%0d expected=0/0/0", bus_if.level, bus_if.ovf, bus_if.drop_cnt); else pass_cnt++;
    chk_cnt++; if (bus_if.rd_data !== 21'h000022) $display("FAIL clr_rd_data actual=%h expected=000022", bus_if.rd_data); else pass_cnt++;
    pop();
    chk_cnt++; if (bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== 21'h000022) $display("FAIL clr_empty_pop actual=%b/%h expected=0/000022", bus_if.rd_valid, bus_if.rd_data); else pass_cnt++;
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 8; i++) pulse(1'b0, 4'd0, 16'(i));
    for (int i = 0; i < 256; i++) pulse(1'b0, 4'd0, 16'hDEAD);
    chk_cnt++; if (bus_if.drop_cnt !== 8'd255 || bus_if.level !== 4'd8) $display("FAIL drop_sat actual=%0d/%0d expected=255/8", bus_if.drop_cnt, bus_if.level); else pass_cnt++;
    pop();
    chk_cnt++; if (bus_if.rd_data !== 21'h0) $display("FAIL drop_contents actual=%h expected=000000", bus_if.rd_data); else pass_cnt++;
    clear();
  endtask

  task automatic test_reset_mid();
    pulse(1'b0, 4'd0, 16'h0077);
    pulse(1'b0, 4'd0, 16'h0078);
    bus_if.rd_en = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++; if (bus_if.level !== 4'd0 || bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== 21'h0) $display("FAIL rst_mid actual=%0d/%b/%h expected=0/0/000000", bus_if.level, bus_if.rd_valid, bus_if.rd_data); else pass_cnt++;
    step();
    bus_if.rd_en = 1'b0;
    chk_cnt++; if (bus_if.rd_valid !== 1'b0 || bus_if.empty !== 1'b1) $display("FAIL rst_mid_pop actual=%b/%b expected=0/1", bus_if.rd_valid, bus_if.empty); else pass_cnt++;
  endtask

  task automatic test_rst_edge();
    rst = 1'b1;
    bus_if.pxl_done_i = 1'b1; bus_if.pxl_q_i = 4'd2; bus_if.data_i = 16'h0055;
    step(); step();
    rst = 1'b0;
    step();
    chk_cnt++; if (bus_if.level !== 4'd1) $display("FAIL rst_edge_level actual=%0d expected=1", bus_if.level); else pass_cnt++;
    step();
    chk_cnt++; if (bus_if.level !== 4'd1) $display("FAIL rst_edge_hold actual=%0d expected=1", bus_if.level); else pass_cnt++;
    bus_if.pxl_done_i = 1'b0;
    pop();
    chk_cnt++; if (bus_if.rd_data !== 21'h020055) $display("FAIL rst_edge_data actual=%h expected=020055", bus_if.rd_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_fill_overflow();
    test_simul_full();
    test_empty_simul();
    test_kernel_tag();
    test_irq();
    test_clear();
    test_drop_saturate();
    test_reset_mid();
    test_rst_edge();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pxl_readout_fifo.md
PXL_READOUT_FIFO -- requirements
Module: pxl_readout_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter DW, default 16: pixel data width, matching the pixel FSM data_out.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port pxl_done_i  input  1  pixel-done level from the pixel FSM.
REQ-006 SHALL have port kernel_done_i  input  1  kernel-done level from the pixel FSM.
REQ-007 SHALL have port pxl_q_i  input  4  index of the pixel being reported.
REQ-008 SHALL have port data_i  input  DW  pixel result word.
REQ-009 SHALL have port rd_en  input  1  pop request from the Wishbone side; one pop per high cycle.
REQ-010 SHALL have port clr_i  input  1  flush the FIFO and clear the sticky status.
REQ-011 SHALL have port irq_thresh  input  $clog2(DEPTH)+1  interrupt level threshold; 0 disables the interrupt.
REQ-012 SHALL have port rd_data  output  DW+5  popped entry {last, pxl_q[3:0], data}.
REQ-013 SHALL have port rd_valid  output  1  rd_data was updated this cycle.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port empty / full  output  1 each  level==0 / level==DEPTH.
REQ-016 SHALL have port ovf  output  1  sticky flag: a capture was dropped.
REQ-017 SHALL have port drop_cnt  output  8  number of dropped captures, saturating at 255.
REQ-018 SHALL have port irq_o  output  1  level interrupt.

Function
REQ-019 SHALL register pxl_done_i and kernel_done_i into prev-flops and detect rising edges (current=1, prev=0).
REQ-020 SHALL raise a capture event in the same cycle as the pxl_done_i rising edge.
- Entry written = {kernel_done_i, pxl_q_i, data_i}, using values sampled in that cycle.
REQ-021 SHALL NOT capture while pxl_done_i stays high; a level held for N cycles yields exactly one entry.
REQ-022 SHALL implement a circular buffer with wr_ptr and rd_ptr, each wrapping DEPTH-1 -> 0.
REQ-023 SHALL, on rd_en with !empty, load rd_data from the rd_ptr entry at the next edge, pulse rd_valid for 1 cycle and advance rd_ptr (read latency 1 cycle).
REQ-024 SHALL ignore rd_en when empty: rd_data holds its value, rd_valid=0, ptr unchanged, no error flagged.
REQ-025 SHALL handle capture and pop in the same cycle as follows:
- not empty, not full: both occur, level unchanged.
- full: both occur, no drop, level stays DEPTH.
- empty: write occurs, pop is ignored, level becomes 1.
REQ-026 SHALL, on capture when full without a valid pop, drop the entry, set ovf=1, and increment drop_cnt (saturating at 255); FIFO contents are untouched.
REQ-027 SHALL update level = level + wr_accepted - rd_accepted every cycle; empty and full are derived from level.
REQ-028 SHALL register irq_o = (irq_thresh!=0) && (level_next >= irq_thresh), so it tracks level with no extra cycle of lag.
REQ-029 SHALL, on clr_i=1, behave as a reset for the following, taking priority over capture and pop in that cycle:
- clears: pointers, level, ovf, drop_cnt, rd_valid, irq_o.
- keeps: rd_data and the edge prev-flops.

Reset
REQ-030 SHALL, on rst=1, clear all of the following to 0 and discard FIFO contents, with priority over every other input:
- pointers, level, rd_data, rd_valid, ovf, drop_cnt, irq_o, prev-flops.
- empty=1, full=0.
REQ-031 SHALL take as the first rising edge after rst deasserts any pxl_done_i=1 already present in the first cycle (prev=0).
REQ-032 SHALL, on rst asserted mid-operation, lose pending entries, and no rd_valid pulse follows.

Verification
REQ-033 Single capture: pxl_done_i high 5 cycles with pxl_q_i=3, data_i=0x1A2B, kernel_done_i=0 -> level=1; then rd_en 1 cycle -> next cycle rd_data=0x031A2B, rd_valid=1, level=0.
REQ-034 Fill and overflow with DEPTH=8: 9 pxl_done pulses, data 1..9, no reads -> full=1, ovf=1, drop_cnt=1; 8 pops return 1..8 in order, then empty=1.
REQ-035 Simultaneous events at full: capture of data 0xBEEF in the same cycle as rd_en -> level stays 8, ovf stays 0, and the last pop of the sequence returns 0xBEEF.
REQ-036 Kernel tag: capture with kernel_done_i=1, pxl_q_i=15, data 0xFFFF -> popped rd_data=0x1FFFFF.
REQ-037 Interrupt: irq_thresh=3, three captures -> irq_o=1 in the cycle level=3; one pop -> irq_o=0; irq_thresh=0 -> irq_o never asserts.
REQ-038 Clear and reset: clr_i with level=5, ovf=1 -> level=0, ovf=0, drop_cnt=0, rd_data unchanged; rd_en on empty -> rd_valid stays 0.
